// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Groups the fetch-side lookup and execute-side update signals of the BTB.
//   master : fetch/execute pipeline side (drives PCF and resolved-branch info)
//   slave  : branch_predictor (drives the prediction back)
// Signals:
//   PCF        fetch PC being looked up
//   updateE    resolved branch/JAL/JALR present in execute
//   PCE        PC of the resolved instruction
//   takenE     resolved direction
//   targetE    resolved target
//   isJumpE    resolved instruction is unconditional
//   flushAll   invalidate the whole table
//   predPCF    predicted next fetch PC
//   predTakenF prediction is taken
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
   parameter int XLEN = 64
);
   logic [XLEN-1:0] PCF;
   logic            updateE;
   logic [XLEN-1:0] PCE;
   logic            takenE;
   logic [XLEN-1:0] targetE;
   logic            isJumpE;
   logic            flushAll;
   logic [XLEN-1:0] predPCF;
   logic            predTakenF;

   modport master (
      output PCF, updateE, PCE, takenE, targetE, isJumpE, flushAll,
      input  predPCF, predTakenF
   );

   modport slave (
      input  PCF, updateE, PCE, takenE, targetE, isJumpE, flushAll,
      output predPCF, predTakenF
   );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter and an unconditional-jump flag per entry.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bp     branch_predictor_if.slave (lookup on PCF, update from execute)
// Lookup is purely combinational; writes become visible the cycle after the
// update edge, so a same-cycle lookup of the written index sees old contents.
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int XLEN    = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_predictor_if.slave    bp
);
   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = XLEN - IDXW - 2;

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] jmp_q;
   logic [TAGW-1:0]    tag_q [ENTRIES];
   logic [XLEN-1:0]    tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];

   // ---------------- lookup ----------------
   logic [IDXW-1:0] f_idx;
   logic [TAGW-1:0] f_tag;
   logic            f_hit;

   assign f_idx = bp.PCF[IDXW+1:2];
   assign f_tag = bp.PCF[XLEN-1:IDXW+2];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   assign bp.predTakenF = f_hit && (ctr_q[f_idx][1] || jmp_q[f_idx]);
   // Sequential PC wraps naturally at the XLEN boundary.
   assign bp.predPCF    = bp.predTakenF ? tgt_q[f_idx] : (bp.PCF + XLEN'(4));

   // ---------------- update ----------------
   logic [IDXW-1:0] e_idx;
   logic [TAGW-1:0] e_tag;
   logic            e_hit;
   logic [1:0]      e_ctr;

   assign e_idx = bp.PCE[IDXW+1:2];
   assign e_tag = bp.PCE[XLEN-1:IDXW+2];
   assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign e_ctr = ctr_q[e_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         jmp_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else if (bp.flushAll) begin
         // Concurrent update is dropped; only valid bits matter afterwards.
         valid_q <= '0;
      end else if (bp.updateE) begin
         if (e_hit) begin
            jmp_q[e_idx] <= bp.isJumpE;
            if (bp.takenE) begin
               tgt_q[e_idx] <= bp.targetE;
               if (e_ctr != 2'b11) ctr_q[e_idx] <= e_ctr + 2'b01;
            end else if (e_ctr != 2'b00) begin
               ctr_q[e_idx] <= e_ctr - 2'b01;
            end
         end else if (bp.takenE) begin
            // Allocate (or evict an aliasing entry) only on a taken miss.
            valid_q[e_idx] <= 1'b1;
            tag_q[e_idx]   <= e_tag;
            tgt_q[e_idx]   <= bp.targetE;
            ctr_q[e_idx]   <= 2'b10;
            jmp_q[e_idx]   <= bp.isJumpE;
         end
      end
   end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, 16, number of direct-mapped BTB entries (power of two, >=2).
REQ-002 Parameter: XLEN, 64, PC/target width (equals data bus width).
REQ-003 Derived: IDXW = log2(ENTRIES); index = PC[IDXW+1:2]; tag = PC[XLEN-1:IDXW+2].
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 PCF  input  XLEN  fetch-stage PC being looked up.
REQ-007 updateE  input  1  execute-stage instruction is a resolved branch/JAL/JALR.
REQ-008 PCE  input  XLEN  PC of the resolved instruction.
REQ-009 takenE  input  1  resolved direction (1 = taken).
REQ-010 targetE  input  XLEN  resolved target (same value the hazard unit compares as PCNextE).
REQ-011 isJumpE  input  1  resolved instruction is unconditional (JAL/JALR).
REQ-012 flushAll  input  1  invalidate the whole table (fence.i).
REQ-013 predPCF  output  XLEN  predicted next fetch PC.
REQ-014 predTakenF  output  1  prediction is taken.

Function
REQ-015 Each entry SHALL hold: valid (1), tag, target (XLEN), 2-bit saturating counter, jump flag (1).
REQ-016 Lookup SHALL be combinational from PCF: hit = valid[idx] & tag match.
REQ-017 predTakenF SHALL be hit & (counter[1] | jump flag).
REQ-018 predPCF SHALL be target[idx] when predTakenF, else PCF + 4 (modulo 2^XLEN, wraps at all-ones).
REQ-019 Update SHALL occur only on a rising edge with updateE=1; table writes are visible to lookups from the next cycle (same-cycle lookup of the written index returns old contents).
REQ-020 Update hit (PCE tag matches valid entry): taken -> counter saturating increment (max 11), target <= targetE; not taken -> counter saturating decrement (min 00), target unchanged; jump flag <= isJumpE.
REQ-021 Update miss, taken: allocate/replace entry: valid<=1, tag<=PCE tag, target<=targetE, counter<=10, jump flag<=isJumpE.
REQ-022 Update miss, not taken: no state change.
REQ-023 flushAll=1 SHALL clear all valid bits at the edge; counters, tags, targets are don't-care afterwards.
REQ-024 Priority per edge: reset > flushAll > updateE (update discarded when flushAll or reset asserted).
REQ-025 PCE[1:0] and PCF[1:0] SHALL be ignored for index/tag.
REQ-026 No stall input: the hazard unit holds PCF during stalls, so output follows PCF combinationally; the block has no multi-cycle latency.

Reset
REQ-027 On reset all valid bits SHALL clear and all counters SHALL be 01; jump flags cleared.
REQ-028 During and after reset, predTakenF=0 and predPCF=PCF+4 for every PCF until a taken update is accepted.
REQ-029 Reset asserted mid-sequence SHALL discard any concurrent update; no partial entry state survives.

Verification (ENTRIES=16, XLEN=64)
REQ-030 After reset, PCF=0x1000 -> predTakenF=0, predPCF=0x1004; PCF=0xFFFF_FFFF_FFFF_FFFC -> predPCF=0x0.
REQ-031 updateE=1, PCE=0x1000, takenE=1, targetE=0x2000, isJumpE=0; next cycle PCF=0x1000 -> predTakenF=1, predPCF=0x2000 (counter 10); same-cycle lookup of 0x1000 during the write -> 0x1004.
REQ-032 From REQ-031 state: two not-taken updates at 0x1000 -> counter 00, predPCF=0x1004; one taken update -> counter 01, still predPCF=0x1004; second taken -> 10, predPCF=0x2000; three more taken -> stays 11.
REQ-033 Aliasing: after REQ-031, taken update PCE=0x1040 (index 0, new tag), targetE=0x3000 -> PCF=0x1040 predicts 0x3000, PCF=0x1000 predicts 0x1004; not-taken update at unallocated 0x1080 -> no change.
REQ-034 Jump: taken update PCE=0x1004, targetE=0x4000, isJumpE=1; then force counter to 00 via two not-taken updates with isJumpE=1 -> predTakenF stays 1, predPCF=0x4000.
REQ-035 flushAll=1 and a taken update (PCE=0x1008) in the same cycle -> next cycle every PCF misses (PCF=0x1000, 0x1008 -> PC+4); reset with concurrent update -> identical empty result.
